// File: rtl/color_classifier.sv
// color_classifier: periodic RGB sampler that commits the dominant color after repeated agreement.
// Optional macro COLOR_CLASS_HOLD_EN: when defined, dark samples leave the classification history and committed color untouched.
module color_classifier #(
   parameter int unsigned SAMPLE_PERIOD = 25000000,
   parameter int unsigned STABLE_COUNT  = 3,
   parameter int unsigned MIN_LEVEL     = 16,
   parameter int unsigned DOM_MARGIN    = 8
)(
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] red_norm,
   input  logic [15:0] green_norm,
   input  logic [15:0] blue_norm,
   input  logic        luz,
   output logic [1:0]  color,
   output logic        color_valid,
   output logic        stable,
   output logic        dark
);
   typedef enum logic [1:0] {S_WAIT, S_CAPTURE, S_EVAL, S_UPDATE} state_t;
   state_t state, state_next;
   logic [31:0] timer;
   logic        timer_done;
   logic [15:0] cap_r, cap_g, cap_b;
   logic        cap_luz;
   logic [1:0]  cand, prev, cand_calc;
   logic [3:0]  run, run_next;
   logic        r_top, g_top, commit, hold;
   logic [15:0] top, sec;
   logic [16:0] lead;
`ifdef COLOR_CLASS_HOLD_EN
   assign hold = cap_luz;
`else
   assign hold = 1'b0;
`endif
   assign timer_done = timer == 32'(SAMPLE_PERIOD - 1);
   // state register
   always_ff @(posedge clk) begin
      if (!rst) state <= S_WAIT;
      else state <= state_next;
   end
   // sequencing plus candidate selection and run-length bookkeeping
   always_comb begin
      state_next = state;
      state_next = (state == S_WAIT)    ? (timer_done ? S_CAPTURE : S_WAIT) :
                   (state == S_CAPTURE) ? S_EVAL :
                   (state == S_EVAL)    ? S_UPDATE : S_WAIT;
      r_top = cap_r >= cap_g && cap_r >= cap_b;
      g_top = !r_top && cap_g >= cap_b;
      top = r_top ? cap_r : g_top ? cap_g : cap_b;
      sec = r_top ? (cap_g >= cap_b ? cap_g : cap_b) :
            g_top ? (cap_r >= cap_b ? cap_r : cap_b) :
                    (cap_r >= cap_g ? cap_r : cap_g);
      lead = {1'b0, top} - {1'b0, sec};
      cand_calc = cap_luz                  ? 2'd0 :
                  top < 16'(MIN_LEVEL)     ? 2'd0 :
                  lead < 17'(DOM_MARGIN)   ? 2'd0 :
                  r_top ? 2'd1 : g_top ? 2'd2 : 2'd3;
      run_next = (cand == prev) ? (run == 4'd15 ? 4'd15 : run + 4'd1) : 4'd1;
      commit = !hold && run_next >= 4'(STABLE_COUNT) && cand != color;
   end
   // datapath: timer, capture, candidate, history and committed outputs
   always_ff @(posedge clk) begin
      if (!rst) begin
         timer       <= '0;
         cap_r       <= '0;
         cap_g       <= '0;
         cap_b       <= '0;
         cap_luz     <= 1'b0;
         cand        <= 2'd0;
         prev        <= 2'd0;
         run         <= '0;
         color       <= 2'd0;
         color_valid <= 1'b0;
         stable      <= 1'b0;
         dark        <= 1'b0;
      end else begin
         color_valid <= 1'b0;
         timer <= (state == S_WAIT && !timer_done) ? timer + 32'd1 : 32'd0;
         if (state == S_CAPTURE) begin
            cap_r   <= red_norm;
            cap_g   <= green_norm;
            cap_b   <= blue_norm;
            cap_luz <= luz;
            dark    <= luz;
         end
         if (state == S_EVAL && !hold) cand <= cand_calc;
         if (state == S_UPDATE) begin
            stable <= commit || cand == color;
            if (!hold) begin
               run  <= run_next;
               prev <= cand;
            end
            if (commit) begin
               color       <= cand;
               color_valid <= 1'b1;
            end
         end
      end
   end
endmodule

// File: tb/tb_color_classifier.sv
// tb_color_classifier: directed checks of sampling, dominance rules, commit pulses and reset abort.
module tb_color_classifier;
   localparam int P  = 4;
   localparam int EV = P + 3;
   logic        clk, rst, luz;
   logic [15:0] r, g, b;
   logic [1:0]  color;
   logic        color_valid, stable, dark;
   int          n_assert = 0;
   int          n_fail = 0;
   int          pulses = 0;
   int          p0;

   color_classifier #(.SAMPLE_PERIOD(P), .STABLE_COUNT(3), .MIN_LEVEL(16), .DOM_MARGIN(8)) dut (
      .clk(clk), .rst(rst), .red_norm(r), .green_norm(g), .blue_norm(b), .luz(luz),
      .color(color), .color_valid(color_valid), .stable(stable), .dark(dark)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // count every cycle in which the commit pulse is high
   always @(posedge clk) if (color_valid === 1'b1) pulses <= pulses + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic wait_evals(input int n);
      repeat (EV * n) @(negedge clk);
   endtask

   task automatic set_rgb(input int rr, input int gg, input int bb, input logic l);
      r = 16'(rr); g = 16'(gg); b = 16'(bb); luz = l;
   endtask

   initial begin
      rst = 1'b0;
      set_rgb(12, 12, 12, 1'b0);
      repeat (3) @(negedge clk);
      check("rst_color", 32'(color), 0);
      check("rst_valid", 32'(color_valid), 0);
      check("rst_stable", 32'(stable), 0);
      check("rst_dark", 32'(dark), 0);
      rst = 1'b1;
      // below MIN_LEVEL: stays NONE, candidate agrees with color
      p0 = pulses;
      wait_evals(3);
      check("low_color", 32'(color), 0);
      check("low_stable", 32'(stable), 1);
      check("low_dark", 32'(dark), 0);
      check("low_pulses", 32'(pulses - p0), 0);
      // clear red dominance commits on the third evaluation
      set_rgb(200, 50, 40, 1'b0);
      p0 = pulses;
      wait_evals(2);
      check("red2_color", 32'(color), 0);
      check("red2_stable", 32'(stable), 0);
      wait_evals(1);
      check("red3_color", 32'(color), 1);
      check("red3_valid", 32'(color_valid), 1);
      check("red3_stable", 32'(stable), 1);
      @(negedge clk);
      check("red3_valid_drop", 32'(color_valid), 0);
      repeat (EV - 1) @(negedge clk);
      wait_evals(9);
      check("red_hold_color", 32'(color), 1);
      check("red_pulses", 32'(pulses - p0), 1);
      // insufficient lead reverts to NONE after three evaluations
      set_rgb(100, 95, 10, 1'b0);
      p0 = pulses;
      wait_evals(1);
      check("margin1_stable", 32'(stable), 0);
      check("margin1_color", 32'(color), 1);
      wait_evals(2);
      check("margin3_color", 32'(color), 0);
      check("margin3_valid", 32'(color_valid), 1);
      wait_evals(1);
      check("margin_pulses", 32'(pulses - p0), 1);
      // alternating green/blue never reaches the run length
      p0 = pulses;
      for (int i = 0; i < 10; i++) begin
         if (i % 2 == 0) set_rgb(0, 300, 0, 1'b0);
         else set_rgb(0, 0, 300, 1'b0);
         wait_evals(1);
         check("alt_stable", 32'(stable), 0);
         check("alt_color", 32'(color), 0);
      end
      check("alt_pulses", 32'(pulses - p0), 0);
      // commit blue, then go dark
      set_rgb(0, 0, 300, 1'b0);
      wait_evals(3);
      check("blue_color", 32'(color), 3);
      check("blue_dark", 32'(dark), 0);
      set_rgb(0, 0, 300, 1'b1);
      p0 = pulses;
      wait_evals(1);
      check("dark1_dark", 32'(dark), 1);
      check("dark1_color", 32'(color), 3);
      wait_evals(2);
`ifdef COLOR_CLASS_HOLD_EN
      check("dark3_color", 32'(color), 3);
`else
      check("dark3_color", 32'(color), 0);
`endif
      wait_evals(1);
      check("dark4_dark", 32'(dark), 1);
      check("dark4_stable", 32'(stable), 1);
`ifdef COLOR_CLASS_HOLD_EN
      check("dark_pulses", 32'(pulses - p0), 0);
`else
      check("dark_pulses", 32'(pulses - p0), 1);
`endif
      // reset during evaluation of the third red sample aborts the commit
      set_rgb(200, 50, 40, 1'b0);
      wait_evals(2);
      repeat (5) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      p0 = pulses;
      check("abort_color", 32'(color), 0);
      check("abort_valid", 32'(color_valid), 0);
      check("abort_stable", 32'(stable), 0);
      check("abort_dark", 32'(dark), 0);
      wait_evals(2);
      check("rerun2_color", 32'(color), 0);
      wait_evals(1);
      check("rerun3_color", 32'(color), 1);
      check("rerun3_valid", 32'(color_valid), 1);
      wait_evals(1);
      check("rerun_pulses", 32'(pulses - p0), 1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule

// File: doc/color_classifier.md
COLOR_CLASSIFIER -- requirements
Module: color_classifier

Interface
REQ-001 Parameter SAMPLE_PERIOD, default 25000000, clk cycles between successive evaluations (range 2 to 2^32-1).
REQ-002 Parameter STABLE_COUNT, default 3, consecutive identical candidates needed to commit a color (range 1 to 15).
REQ-003 Parameter MIN_LEVEL, default 16, minimum dominant channel value for a non-NONE candidate.
REQ-004 Parameter DOM_MARGIN, default 8, minimum lead of the dominant channel over the second-highest channel.
REQ-005 clk  input  1  rising-edge clock.
REQ-006 rst  input  1  reset, synchronous, active-low.
REQ-007 red_norm  input  16  normalized red from the color sensor stage.
REQ-008 green_norm  input  16  normalized green.
REQ-009 blue_norm  input  16  normalized blue.
REQ-010 luz  input  1  1 = ambient too dark, 0 = enough light.
REQ-011 color  output  2  committed color: 0 NONE, 1 RED, 2 GREEN, 3 BLUE.
REQ-012 color_valid  output  1  one-cycle pulse when color changes value.
REQ-013 stable  output  1  high when the latest candidate equals color.
REQ-014 dark  output  1  registered copy of luz, sampled at capture.

Function
REQ-015 The FSM SHALL have four states: S_WAIT, S_CAPTURE, S_EVAL, S_UPDATE.
REQ-016 S_WAIT: timer counts 0 to SAMPLE_PERIOD-1; at terminal count, timer clears and next state is S_CAPTURE.
REQ-017 S_CAPTURE (1 cycle): red_norm, green_norm, blue_norm and luz are registered; next state is S_EVAL.
REQ-018 S_EVAL (1 cycle): the candidate is computed from captured values and registered; next state is S_UPDATE.
REQ-019 Candidate rule, first match wins: captured luz=1 -> NONE; max channel < MIN_LEVEL -> NONE; max minus second-highest < DOM_MARGIN (includes exact ties) -> NONE; otherwise the dominant channel's code.
REQ-020 Comparisons are unsigned 16-bit; the difference is computed at 17 bits, so there is no wrap.
REQ-021 S_UPDATE (1 cycle) updates the run count: if candidate equals the previous candidate, run count increments and saturates at 15; otherwise run count becomes 1 and the previous candidate becomes the candidate.
REQ-022 In S_UPDATE, if the updated run count is at least STABLE_COUNT and candidate differs from color, color takes the candidate on that edge and color_valid is high for exactly the following cycle.
REQ-023 color_valid SHALL never be asserted when color is unchanged; at most one pulse occurs per evaluation.
REQ-024 stable and dark update on the edge leaving S_UPDATE and S_CAPTURE respectively, and hold otherwise.
REQ-025 Evaluation period is SAMPLE_PERIOD+3 cycles; input changes outside S_CAPTURE have no effect.
REQ-026 Input changes arriving in the same cycle as S_CAPTURE are the values captured.

Reset
REQ-027 While rst=0 at a clock edge: state goes to S_WAIT; timer, run count and previous candidate clear to 0/NONE; color=0, color_valid=0, stable=0, dark=0.
REQ-028 Reset asserted in any state, including mid S_EVAL or S_UPDATE, aborts the evaluation; no commit or pulse occurs.
REQ-029 After release, the first capture occurs SAMPLE_PERIOD cycles later.

Configuration
REQ-030 Macro COLOR_CLASS_HOLD_EN defined: when captured luz=1, the candidate, run count and previous candidate are left unchanged and color is held; only dark and stable update.
REQ-031 Macro COLOR_CLASS_HOLD_EN undefined: luz=1 yields candidate NONE per REQ-019.

Verification
Bench parameters: SAMPLE_PERIOD=4, STABLE_COUNT=3, MIN_LEVEL=16, DOM_MARGIN=8.
REQ-032 R=200, G=50, B=40, luz=0 held -> color=1 after the 3rd evaluation with a single color_valid pulse; stable=1; no further pulses over 10 more evaluations.
REQ-033 R=100, G=95, B=10 (lead 5 < 8), starting from committed RED -> NONE committed after 3 evaluations, with one pulse.
REQ-034 All channels = 12 (below MIN_LEVEL) from reset -> color stays 0, no pulse; stable=1.
REQ-035 Inputs alternate GREEN (G=300) and BLUE (B=300) every evaluation for 10 evaluations -> color never changes, no pulse, stable=0 whenever the candidate differs from color.
REQ-036 Committed BLUE, then luz=1 for 4 evaluations -> without macro: color=0 after the 3rd evaluation, dark=1; with COLOR_CLASS_HOLD_EN: color stays 3, no pulse, dark=1.
REQ-037 rst=0 for one cycle during S_EVAL of the 3rd qualifying RED evaluation -> next cycle all outputs 0, state S_WAIT; with inputs still RED, commit requires 3 new evaluations.
